// File: rtl/soc_evt_pkg.sv
// soc_evt_bridge shared package
// ID type, default sizes and popcount helper
package soc_evt_pkg;

  localparam int NB_EVT_DEF     = 32;
  localparam int EVNT_WIDTH_DEF = 8;
  localparam int CNT_W_DEF      = 16;
  localparam int POP_MAX        = 256;

  typedef logic [EVNT_WIDTH_DEF-1:0] evt_id_t;

  function automatic logic [31:0] popcount(
    input logic [POP_MAX-1:0] v
  );
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < POP_MAX; i++)
      n = n + 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/soc_evt_rr_arb.sv
// Round-robin arbiter, purely combinational
// Picks first request at or after ptr, cyclically
module soc_evt_rr_arb #(
  parameter int N  = 32,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic          o_gnt_valid,
  output logic [PW-1:0] o_gnt_idx,
  output logic [PW-1:0] o_next_ptr
);

  // cyclic scan starting at ptr, first hit wins
  always_comb begin
    int j;
    j           = 0;
    o_gnt_valid = 1'b0;
    o_gnt_idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(i_ptr) + k;
      if (j >= N)
        j = j - N;
      if (!o_gnt_valid && i_req[PW'(j)]) begin
        o_gnt_valid = 1'b1;
        o_gnt_idx   = PW'(j);
      end
    end
  end

  assign o_next_ptr = (o_gnt_idx == PW'(N-1)) ? '0
                    : o_gnt_idx + PW'(1);

endmodule

// File: rtl/soc_evt_bridge.sv
// SoC peripheral event bridge
// Pulses -> pending bits -> RR -> one valid/ready slot
module soc_evt_bridge
  import soc_evt_pkg::*;
#(
  parameter int NB_EVT     = NB_EVT_DEF,
  parameter int EVNT_WIDTH = EVNT_WIDTH_DEF,
  parameter int EVT_BASE   = 0,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NB_EVT-1:0]     evt_i,
  output logic                  evt_valid_o,
  input  logic                  evt_ready_i,
  output logic [EVNT_WIDTH-1:0] evt_data_o,
  output logic [NB_EVT-1:0]     lost_o,
  input  logic                  lost_clr_i,
  output logic [CNT_W-1:0]      lost_cnt_o,
  output logic                  busy_o
);

  localparam int PW = $clog2(NB_EVT);
  localparam logic [32:0] CNT_MAX = 33'({CNT_W{1'b1}});

  logic [NB_EVT-1:0]     r_pend;
  logic [PW-1:0]         r_ptr;
  logic                  r_valid;
  logic [EVNT_WIDTH-1:0] r_data;
  logic [NB_EVT-1:0]     r_lost;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_slot_free;
  logic                  w_gnt_valid;
  logic [PW-1:0]         w_gnt_idx;
  logic [PW-1:0]         w_next_ptr;
  logic                  w_gnt;
  logic [NB_EVT-1:0]     w_gnt_vec;
  logic [NB_EVT-1:0]     w_loss;
  logic [31:0]           w_pc;
  logic [32:0]           w_sum;
  logic [CNT_W-1:0]      w_cnt_nxt;

  soc_evt_rr_arb #(
    .N  (NB_EVT),
    .PW (PW)
  ) u_arb (
    .i_req       (r_pend),
    .i_ptr       (r_ptr),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_idx   (w_gnt_idx),
    .o_next_ptr  (w_next_ptr)
  );

  assign w_slot_free = !r_valid || evt_ready_i;
  assign w_gnt       = w_slot_free && w_gnt_valid;
  assign w_gnt_vec   = w_gnt ? (NB_EVT'(1) << w_gnt_idx)
                     : '0;
  assign w_loss      = evt_i & r_pend & ~w_gnt_vec;

  // saturating loss count; clear restarts from this cycle's losses
  always_comb begin
    w_pc  = popcount(POP_MAX'(w_loss));
    w_sum = (lost_clr_i ? 33'd0 : 33'(r_cnt))
          + 33'(w_pc);
    w_cnt_nxt = (w_sum > CNT_MAX) ? '1 : CNT_W'(w_sum);
  end

  // pending bits, arbitration pointer and output slot
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend  <= '0;
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_pend <= (r_pend & ~w_gnt_vec) | evt_i;
      if (w_slot_free)
        r_valid <= w_gnt_valid;
      if (w_gnt) begin
        r_data <= EVNT_WIDTH'(EVT_BASE)
                + EVNT_WIDTH'(w_gnt_idx);
        r_ptr  <= w_next_ptr;
      end
    end
  end

  // sticky lost flags and counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lost <= '0;
      r_cnt  <= '0;
    end else begin
      r_lost <= (lost_clr_i ? '0 : r_lost) | w_loss;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign evt_valid_o = r_valid;
  assign evt_data_o  = r_data;
  assign lost_o      = r_lost;
  assign lost_cnt_o  = r_cnt;
  assign busy_o      = r_valid || (|r_pend);

endmodule

// File: tb/tb_soc_evt_bridge.sv
// soc_evt_bridge directed bench
// Hand-computed expectations, one check task
module tb_soc_evt_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] evt;
  logic        ready;
  logic        clr;
  logic        valid;
  logic [7:0]  data;
  logic [31:0] lost;
  logic [15:0] cnt;
  logic        busy;

  logic [7:0]  s_evt;
  logic        s_ready;
  logic        s_clr;
  logic        s_valid;
  logic [7:0]  s_data;
  logic [7:0]  s_lost;
  logic [1:0]  s_cnt;
  logic        s_busy;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  soc_evt_bridge dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .evt_i       (evt),
    .evt_valid_o (valid),
    .evt_ready_i (ready),
    .evt_data_o  (data),
    .lost_o      (lost),
    .lost_clr_i  (clr),
    .lost_cnt_o  (cnt),
    .busy_o      (busy)
  );

  soc_evt_bridge #(
    .NB_EVT (8),
    .CNT_W  (2)
  ) dut_sat (
    .clk_i       (clk),
    .rst_i       (rst),
    .evt_i       (s_evt),
    .evt_valid_o (s_valid),
    .evt_ready_i (s_ready),
    .evt_data_o  (s_data),
    .lost_o      (s_lost),
    .lost_clr_i  (s_clr),
    .lost_cnt_o  (s_cnt),
    .busy_o      (s_busy)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    evt = '0; ready = 1'b0; clr = 1'b0;
    s_evt = '0; s_ready = 1'b0; s_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_data",  64'(data),  64'd0);
    chk("rst_lost",  64'(lost),  64'd0);
    chk("rst_cnt",   64'(cnt),   64'd0);
    chk("rst_busy",  64'(busy),  64'd0);

    // single event, latency 2
    ready = 1'b1;
    evt = 32'h1 << 5;
    tick();
    evt = '0;
    chk("single_t1_valid", 64'(valid), 64'd0);
    chk("single_t1_busy",  64'(busy),  64'd1);
    tick();
    chk("single_t2_valid", 64'(valid), 64'd1);
    chk("single_t2_data",  64'(data),  64'd5);
    tick();
    chk("single_t3_valid", 64'(valid), 64'd0);
    chk("single_t3_busy",  64'(busy),  64'd0);

    // round robin over all lines
    do_reset();
    ready = 1'b1;
    evt = 32'hFFFF_FFFF;
    tick();
    evt = '0;
    chk("rr_t1_valid", 64'(valid), 64'd0);
    tick();
    for (int i = 0; i < 32; i++) begin
      chk("rr_valid", 64'(valid), 64'd1);
      chk("rr_data",  64'(data),  64'(i));
      tick();
    end
    chk("rr_drain", 64'(valid), 64'd0);
    evt = (32'h1 << 3) | (32'h1 << 1);
    tick();
    evt = '0;
    tick();
    chk("rr_wrap_a", 64'(data), 64'd1);
    tick();
    chk("rr_wrap_b", 64'(data), 64'd3);
    tick();
    chk("rr_wrap_end", 64'(valid), 64'd0);

    // backpressure holds the slot
    do_reset();
    evt = (32'h1 << 2) | (32'h1 << 7);
    tick();
    evt = '0;
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("bp_hold", {55'd0, valid, data}, {55'd0, 1'b1, 8'd2});
      tick();
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("bp_next", {55'd0, valid, data}, {55'd0, 1'b1, 8'd7});
    chk("bp_lost", 64'(lost), 64'd0);
    chk("bp_cnt",  64'(cnt),  64'd0);

    // loss with the slot blocked
    do_reset();
    evt = 32'h1;
    tick();
    evt = '0;
    tick();
    chk("loss_slot", {55'd0, valid, data}, {55'd0, 1'b1, 8'd0});
    for (int i = 0; i < 3; i++) begin
      evt = 32'h1 << 4;
      tick();
    end
    evt = '0;
    chk("loss_flag", 64'(lost), 64'(32'h1 << 4));
    chk("loss_cnt",  64'(cnt),  64'd2);
    evt = 32'h1 << 9;
    tick();
    chk("loss_nolose", 64'(cnt), 64'd2);
    evt = 32'h1 << 9;
    clr = 1'b1;
    tick();
    evt = '0;
    clr = 1'b0;
    chk("clr_flag", 64'(lost), 64'(32'h1 << 9));
    chk("clr_cnt",  64'(cnt),  64'd1);
    chk("clr_slot", {55'd0, valid, data}, {55'd0, 1'b1, 8'd0});

    // counter saturation, CNT_W=2
    do_reset();
    s_evt = 8'h01;
    tick();
    s_evt = '0;
    tick();
    chk("sat_slot", 64'(s_valid), 64'd1);
    s_evt = 8'b0000_0110;
    tick();
    chk("sat_c0", 64'(s_cnt), 64'd0);
    tick();
    chk("sat_c2", 64'(s_cnt), 64'd2);
    tick();
    chk("sat_c3a", 64'(s_cnt), 64'd3);
    tick();
    chk("sat_c3b", 64'(s_cnt), 64'd3);
    chk("sat_flags", 64'(s_lost), 64'h06);
    s_evt = '0;
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    chk("sat_clr", 64'(s_cnt), 64'd0);

    // reset mid-operation
    do_reset();
    evt = 32'h1;
    tick();
    evt = (32'h1 << 3) | (32'h1 << 5) | (32'h1 << 6);
    tick();
    evt = '0;
    chk("mid_valid", 64'(valid), 64'd1);
    tick();
    chk("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_out",
        {21'd0, valid, data, cnt, busy},
        64'd0);
    chk("mid_rst_lost", 64'(lost), 64'd0);
    ready = 1'b1;
    evt = 32'h1 | (32'h1 << 4);
    tick();
    evt = '0;
    tick();
    chk("mid_first", {55'd0, valid, data}, {55'd0, 1'b1, 8'd0});
    tick();
    chk("mid_second", {55'd0, valid, data}, {55'd0, 1'b1, 8'd4});
    tick();
    chk("mid_idle", {62'd0, valid, busy}, 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/soc_evt_bridge.md
# soc_evt_bridge

Collects single-cycle event pulses from the SoC peripherals and serialises them into the one valid/ready event-ID stream consumed by the cluster event unit's SoC peripheral event FIFO (`soc_periph_evt_valid_i`/`ready_o`/`data_i`). Each line has one pending bit. Lines are served by a round-robin arbiter into a single registered output slot. Back-to-back pulses on a line that is already pending are counted as lost and flagged per line for software diagnosis.

## Interface
Parameters:
- `NB_EVT`, default 32: number of peripheral event lines. Constraint: 2 ≤ `NB_EVT`, and `EVT_BASE`+`NB_EVT` ≤ 2^`EVNT_WIDTH`.
- `EVNT_WIDTH`, default 8: width of the event ID; matches the event unit's `EVNT_WIDTH`.
- `EVT_BASE`, default 0: ID emitted for line 0; line i emits `EVT_BASE`+i.
- `CNT_W`, default 16: width of the lost-event counter.

Ports:
- `clk_i`  in  1  clock. One clock domain; all inputs are synchronous to `clk_i`.
- `rst_i`  in  1  reset, synchronous, active-high.
- `evt_i`  in  `NB_EVT`  event pulses; each cycle a bit is high counts as one event.
- `evt_valid_o`  out  1  output slot holds an event.
- `evt_ready_i`  in  1  consumer accepts the event (the event unit FIFO's not-full).
- `evt_data_o`  out  `EVNT_WIDTH`  event ID of the slot.
- `lost_o`  out  `NB_EVT`  sticky per-line lost flags.
- `lost_clr_i`  in  1  clears `lost_o` and `lost_cnt_o`.
- `lost_cnt_o`  out  `CNT_W`  saturating count of lost events.
- `busy_o`  out  1  asserted when any pending bit is set or `evt_valid_o` is high.

## Operation
- **Pending bits.** `pend[i]` sets when `evt_i[i]`=1. It clears when line i is granted, unless `evt_i[i]`=1 in the same cycle; then it stays set and nothing is lost.
- **Loss.** A loss on line i occurs when `evt_i[i]`=1, `pend[i]`=1 and line i is not granted that cycle. On a loss:
  - `lost_o[i]` is set.
  - `lost_cnt_o` increases by the popcount of that cycle's losses, saturating at all-ones.
- **Slot free.** `slot_free` = !`evt_valid_o` | `evt_ready_i`.
- **Grant.** When `slot_free` and any `pend` bit is set:
  - Grant the first set index at or after `ptr`, searching cyclically.
  - Load `evt_data_o` = `EVT_BASE`+idx and set `evt_valid_o`.
  - Set `ptr` = idx+1, wrapping to 0 after `NB_EVT`-1.
- **Release.** When `slot_free` and no bit is pending, `evt_valid_o` deasserts.
- **Grant source.** The arbiter sees the registered `pend` only. An event arriving in cycle t is eligible in cycle t+1.
- **Clear.**
  - `lost_clr_i` clears `lost_o` and `lost_cnt_o`.
  - Losses in the same cycle take priority: their `lost_o` bits end set and `lost_cnt_o` = popcount of those losses.
- **Handshake.**
  - `evt_valid_o` and `evt_data_o` stay stable while `evt_valid_o`=1 and `evt_ready_i`=0.
  - `evt_valid_o` never depends combinationally on `evt_ready_i`.
- **Reset.** All outputs are 0; `pend`=0, `ptr`=0. Reset in the middle of operation discards pending events and the slot contents without counting them as lost.

## Timing
- Pulse on `evt_i` in cycle t: `pend` is set at the t+1 edge, and `evt_valid_o`=1 in t+2 if the slot is free (latency 2).
- Throughput is one event per cycle with `evt_ready_i` held high.
- With `evt_ready_i`=1 and a continuous backlog, `evt_valid_o` stays high every cycle.
- Fairness: under saturation each pending line waits at most `NB_EVT` grants.
- `lost_o`, `lost_cnt_o` and `busy_o` are registered or derived from registers only, with no combinational paths from inputs.

## Structure
- Package `soc_evt_pkg` holds:
  - `evt_id_t` (`logic [EVNT_WIDTH-1:0]`);
  - the default constants for `NB_EVT`, `EVNT_WIDTH` and `CNT_W`;
  - the popcount function used for `lost_cnt_o`.
- Sub-module `soc_evt_rr_arb`, parameterised by N. Purely combinational.
  - Inputs: request vector, `ptr`.
  - Outputs: `gnt_valid`, `gnt_idx`, `next_ptr`.
- The top level holds `pend`, the slot register, `ptr`, and the loss logic.

## Test plan
- **Single event:** after reset, `evt_i[5]` pulses for one cycle in cycle 10 with `evt_ready_i`=1 → `evt_valid_o`=1 and `evt_data_o`=5 in cycle 12 only; `busy_o` returns to 0 in cycle 13.
- **Round robin:** `evt_i`=32'hFFFF_FFFF for one cycle with ready held high → IDs 0,1,…,31 on 32 consecutive cycles; then lines 3 and 1 pulse → 1 then 3 are emitted (`ptr` wrapped to 0).
- **Backpressure:** `evt_ready_i`=0 while lines 2 and 7 pulse → the slot shows ID 2, stable for 20 cycles; ready high for one cycle → ID 7 in the next cycle, and no loss.
- **Loss:** with ready low, line 4 pulses 3 times (while pending, never granted) → `lost_o[4]`=1 and `lost_cnt_o`=2; then `lost_clr_i` pulses together with a new loss on line 9 → `lost_o` has only bit 9 set and `lost_cnt_o`=1.
- **Saturation:** `CNT_W`=2, repeated losses → `lost_cnt_o` sticks at 3.
- **Reset mid-operation:** `rst_i` is asserted with the slot valid and 3 lines pending → the next cycle shows all outputs 0; after release the first event emitted is line 0, proving `ptr`=0.
